// File: rtl/rx_frame_asm.sv
// Frame assembler for a byte-oriented UART receiver.
// Collects NBYTES bytes into a frame, with optional XOR check and inter-byte timeout.
module rx_frame_asm #(
  parameter int unsigned DW      = 8,
  parameter int unsigned NBYTES  = 4,
  parameter int unsigned CHK_EN  = 1,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxen,
  input  logic                   rnpd,
  input  logic [DW-1:0]          rxpd,
  output logic [NBYTES*DW-1:0]   frame,
  output logic                   rcv_done,
  output logic                   rcv_err,
  output logic [1:0]             err_code,
  output logic                   busy,
  output logic [15:0]            good_cnt
);

  localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = (TMO_CYC == 0) ? '0 : TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_EVAL
  } state_t;

  state_t                r_state;
  logic                  r_rxen_x0, r_rxen_x1;
  logic                  r_rnpd_x0, r_rnpd_x1;
  logic                  r_live, r_armed;
  logic [CW-1:0]         r_count;
  logic [DW-1:0]         r_xor;
  logic [TW-1:0]         r_timer;
  logic [NBYTES*DW-1:0]  r_buf;
  logic [NBYTES*DW-1:0]  r_frame;
  logic                  r_done, r_err, r_busy;
  logic [1:0]            r_code;
  logic [15:0]           r_good_cnt;

  logic w_rxen_rise, w_rnpd_rise, w_tmo, w_chk_ok;

  // A frame start needs rxen seen low after reset, so a level held high
  // through reset is not mistaken for a fresh rising edge.
  assign w_rxen_rise = r_rxen_x0 & ~r_rxen_x1 & r_armed;
  assign w_rnpd_rise = r_rnpd_x0 & ~r_rnpd_x1;
  assign w_tmo       = (TMO_CYC != 0) && (r_timer == TMO_LAST);
  assign w_chk_ok    = (CHK_EN == 0) || (r_xor == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rxen_x0  <= 1'b0;
      r_rxen_x1  <= 1'b0;
      r_rnpd_x0  <= 1'b0;
      r_rnpd_x1  <= 1'b0;
      r_live     <= 1'b0;
      r_armed    <= 1'b0;
      r_count    <= '0;
      r_xor      <= '0;
      r_timer    <= '0;
      r_buf      <= '0;
      r_frame    <= '1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_code     <= 2'b00;
      r_good_cnt <= '0;
    end else begin
      r_rxen_x0 <= rxen;
      r_rxen_x1 <= r_rxen_x0;
      r_rnpd_x0 <= rnpd;
      r_rnpd_x1 <= r_rnpd_x0;
      r_live    <= 1'b1;
      if (r_live && !r_rxen_x0)
        r_armed <= 1'b1;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rxen_rise) begin
            r_state <= S_RECV;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_xor   <= '0;
            r_timer <= '0;
          end
        end
        S_RECV: begin
          // Priority: abort, then strobe, then timeout.
          if (!r_rxen_x1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_rnpd_rise) begin
            r_buf[r_count*DW +: DW] <= rxpd;
            r_count <= r_count + CW'(1);
            r_xor   <= r_xor ^ rxpd;
            r_timer <= '0;
            if (r_count == LAST_IDX) begin
              r_state <= S_EVAL;
              r_busy  <= 1'b0;
            end
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_code  <= 2'b10;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_EVAL: begin
          r_state <= S_IDLE;
          if (w_chk_ok) begin
            r_frame    <= r_buf;
            r_done     <= 1'b1;
            r_good_cnt <= r_good_cnt + 16'd1;
          end else begin
            r_err  <= 1'b1;
            r_code <= 2'b01;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign frame    = r_frame;
  assign rcv_done = r_done;
  assign rcv_err  = r_err;
  assign err_code = r_code;
  assign busy     = r_busy;
  assign good_cnt = r_good_cnt;

endmodule

// File: doc/rx_frame_asm.md
RX_FRAME_ASM -- requirements
Module: rx_frame_asm

Interface
REQ-001 Parameter DW, default 8, data byte width in bits (legal 4..16).
REQ-002 Parameter NBYTES, default 4, bytes per frame including the checksum byte (legal 2..16).
REQ-003 Parameter CHK_EN, default 1: 1 = last byte is an XOR checksum; 0 = no check.
REQ-004 Parameter TMO_CYC, default 1024, inter-byte timeout in clk cycles; 0 disables the timeout.
REQ-005 clk  in  1  sole clock, all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 rxen  in  1  frame enable level from the UART receiver; rising edge starts a frame, low aborts it.
REQ-008 rnpd  in  1  byte-ready strobe; rising edge marks rxpd valid.
REQ-009 rxpd  in  DW  received byte, stable from the rnpd rising edge for at least 3 clk cycles.
REQ-010 frame  out  NBYTES*DW  last good frame; byte k sits at bits [k*DW +: DW], byte 0 received first.
REQ-011 rcv_done  out  1  one-cycle pulse when frame is updated.
REQ-012 rcv_err  out  1  one-cycle pulse when a frame is rejected.
REQ-013 err_code  out  2  cause of the last rejection: 01 checksum, 10 timeout; held until the next error.
REQ-014 busy  out  1  high while the FSM is in RECV.
REQ-015 good_cnt  out  16  count of accepted frames; wraps from FFFF to 0000.

Function
REQ-016 rxen and rnpd SHALL each pass through two flops (x0, x1); rise = x0 & ~x1.
REQ-017 FSM states SHALL be IDLE, RECV, EVAL.
REQ-018 IDLE -> RECV on rxen rise; on that transition clear the byte count, running XOR and timer.
REQ-019 In RECV, on each rnpd rise, write rxpd into buffer slot [count], increment count, fold rxpd into the XOR, and clear the timer.
REQ-020 If the captured byte is slot NBYTES-1, go to EVAL on the same edge.
REQ-021 EVAL lasts exactly one cycle, then the FSM returns to IDLE.
REQ-022 EVAL pass (CHK_EN=0, or final XOR over all NBYTES bytes == 0): load frame from the buffer, pulse rcv_done, increment good_cnt.
REQ-023 EVAL fail: frame unchanged, pulse rcv_err, err_code=01.
REQ-024 Latency: rcv_done/rcv_err SHALL assert in the cycle after the final-byte capture edge; frame is valid in the same cycle as rcv_done.
REQ-025 Timer increments each RECV cycle without an rnpd rise.
REQ-026 When TMO_CYC != 0 and the timer reaches TMO_CYC-1 with no rnpd rise, go to IDLE, pulse rcv_err, err_code=10.
REQ-027 Synchronised rxen low in RECV SHALL abort silently: go to IDLE, no pulse, frame and err_code unchanged.
REQ-028 rnpd rise in IDLE or EVAL SHALL be ignored, with no buffer write.
REQ-029 rxen rise and rnpd rise in the same cycle in IDLE: start the frame, ignore the strobe.
REQ-030 rnpd rise in the same cycle as timeout expiry: the strobe wins and the timer clears.
REQ-031 Abort (rxen low) takes priority over both rnpd rise and timeout.
REQ-032 A new rxen rise during RECV SHALL be ignored; only a low level aborts.
REQ-033 rcv_done and rcv_err SHALL never be high in the same cycle.

Reset
REQ-034 While rst=0 at a clk edge:
- state=IDLE; count, XOR, timer and synchroniser flops = 0.
- frame = all ones; rcv_done=0, rcv_err=0, err_code=00, busy=0, good_cnt=0.
REQ-035 Reset mid-frame SHALL discard the partial frame with no pulse.
REQ-036 After rst returns to 1, the first frame SHALL require a fresh rxen rise.

Verification
REQ-037 Defaults; rxen rise; bytes 11,22,33,00 (XOR 00) -> rcv_done once, frame=00332211, good_cnt=1, busy low next cycle.
REQ-038 Defaults; bytes 11,22,33,01 -> rcv_err once, err_code=01, frame still FFFFFFFF, good_cnt=0.
REQ-039 TMO_CYC=16; two bytes, then no strobe -> rcv_err 16 cycles after the last capture, err_code=10, busy=0.
REQ-040 rxen dropped after byte 2, then a new full frame AA,55,00,FF -> no pulse at the abort, then rcv_done, frame=FF0055AA.
REQ-041 rst=0 asserted after byte 3 for one cycle, then a full good frame -> no pulse for the aborted frame, one rcv_done, good_cnt=1.
REQ-042 good_cnt preset to FFFF via 65535 good frames (or a forced value), one more good frame -> good_cnt=0000.
